// File: rtl/sw_pkg.sv
// Shared state encoding and BCD digit limits for the stopwatch timing path.
package sw_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        LAP_RUN  = 2'd2,
        LAP_STOP = 2'd3
    } swState_t;
endpackage

// File: rtl/bcd_time_counter.sv
// Four-digit SS.hh BCD counter (00.00-59.99). It advances on the edge where inc is high.
// wrap is a combinational pulse that is high during the increment from 59.99 to 00.00.
module bcd_time_counter
    import sw_pkg::*;
(
    input  logic        clk5,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] timeBcd,
    output logic        wrap
);
    logic [BCD_W-1:0] s10, s1, h10, h1;
    logic h1Max, h10Max, s1Max, s10Max;

    assign h1Max  = (h1  == DIGIT_MAX);
    assign h10Max = (h10 == DIGIT_MAX);
    assign s1Max  = (s1  == DIGIT_MAX);
    assign s10Max = (s10 == SEC_TENS_MAX);

    assign wrap    = inc && h1Max && h10Max && s1Max && s10Max;
    assign timeBcd = {s10, s1, h10, h1};

    // A digit moves only when every lower digit is at its maximum, so no non-BCD value can appear.
    always_ff @(posedge clk5) begin
        if (reset || clr) begin
            s10 <= '0;
            s1  <= '0;
            h10 <= '0;
            h1  <= '0;
        end else if (inc) begin
            h1 <= h1Max ? '0 : h1 + 1'b1;
            if (h1Max) begin
                h10 <= h10Max ? '0 : h10 + 1'b1;
                if (h10Max) begin
                    s1 <= s1Max ? '0 : s1 + 1'b1;
                    if (s1Max) begin
                        s10 <= s10Max ? '0 : s10 + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: run/stop/lap FSM, 10 ms tick prescaler, BCD time counter, display mux.
// The tick is registered. The count is visible one cycle after the tick. The display mux adds no latency.
module stopwatch_lap_ctrl
    import sw_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic        clk5,
    input  logic        reset,
    input  logic        start_pb,
    input  logic        stop_pb,
    input  logic        lap_pb,
    input  logic        clear_pb,
    output logic        run,
    output logic        tick,
    output logic [15:0] time_bcd,
    output logic [15:0] disp_bcd,
    output logic        lap_active,
    output logic        ovf
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    swState_t      state;
    logic [PW-1:0] presc;
    logic [15:0]   lapReg;
    logic          clearNow;
    logic          wrap;

    // A clear has the lowest priority. It applies only when no start or lap pulse acts in the same cycle.
    assign clearNow = clear_pb && !start_pb &&
                      ((state == STOPPED) || ((state == LAP_STOP) && !lap_pb));

    assign run        = (state == RUNNING) || (state == LAP_RUN);
    assign lap_active = (state == LAP_RUN) || (state == LAP_STOP);
    assign disp_bcd   = lap_active ? lapReg : time_bcd;

    always_ff @(posedge clk5) begin
        if (reset) begin
            state  <= STOPPED;
            lapReg <= '0;
        end else begin
            unique case (state)
                STOPPED: begin
                    if (start_pb) state <= RUNNING;
                end
                RUNNING: begin
                    if (stop_pb) begin
                        state <= STOPPED;
                    end else if (lap_pb) begin
                        state  <= LAP_RUN;
                        lapReg <= time_bcd;
                    end
                end
                LAP_RUN: begin
                    if (stop_pb)     state <= LAP_STOP;
                    else if (lap_pb) state <= RUNNING;
                end
                LAP_STOP: begin
                    if (lap_pb) begin
                        state <= STOPPED;
                    end else if (start_pb) begin
                        state <= LAP_RUN;
                    end else if (clearNow) begin
                        state  <= STOPPED;
                        lapReg <= '0;
                    end
                end
            endcase
        end
    end

    // The prescaler holds while the watch is halted, so a partial tick period survives a stop/start.
    always_ff @(posedge clk5) begin
        if (reset || clearNow) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (run) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                tick  <= 1'b1;
            end else begin
                presc <= presc + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk5) begin
        if (reset || clearNow) ovf <= 1'b0;
        else if (wrap)         ovf <= 1'b1;
    end

    bcd_time_counter u_counter (
        .clk5    (clk5),
        .reset   (reset),
        .inc     (tick),
        .clr     (clearNow),
        .timeBcd (time_bcd),
        .wrap    (wrap)
    );
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl with CLK_DIV=4. Inputs are driven and outputs sampled on the falling edge.
module tb_stopwatch_lap_ctrl;
    logic        clk5 = 1'b0;
    logic        reset = 1'b1;
    logic        start_pb = 1'b0, stop_pb = 1'b0, lap_pb = 1'b0, clear_pb = 1'b0;
    logic        run, tick, lap_active, ovf;
    logic [15:0] time_bcd, disp_bcd;
    int          nAssert = 0;
    int          nFail = 0;

    stopwatch_lap_ctrl #(.CLK_DIV(4)) dut (
        .clk5       (clk5),
        .reset      (reset),
        .start_pb   (start_pb),
        .stop_pb    (stop_pb),
        .lap_pb     (lap_pb),
        .clear_pb   (clear_pb),
        .run        (run),
        .tick       (tick),
        .time_bcd   (time_bcd),
        .disp_bcd   (disp_bcd),
        .lap_active (lap_active),
        .ovf        (ovf)
    );

    always #5 clk5 = ~clk5;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk5);
            @(negedge clk5);
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic l, input logic c);
        start_pb = s; stop_pb = p; lap_pb = l; clear_pb = c;
        cyc(1);
        start_pb = 1'b0; stop_pb = 1'b0; lap_pb = 1'b0; clear_pb = 1'b0;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        chk1("rst_run", run, 1'b0);
        chk1("rst_tick", tick, 1'b0);
        chk1("rst_lap", lap_active, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        chk16("rst_time", time_bcd, 16'h0000);
        chk16("rst_disp", disp_bcd, 16'h0000);

        // The first tick comes 4 cycles after run rises, then every 4 cycles.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk1("start_run", run, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            chk1("tick_pattern", tick, (i % 4) == 0);
        end
        cyc(1);
        chk16("four_ticks_time", time_bcd, 16'h0004);
        chk16("four_ticks_disp", disp_bcd, 16'h0004);

        // Freeze the display at 00.37 and then release it.
        cyc(132);
        chk16("time_0037", time_bcd, 16'h0037);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk1("lap_active_on", lap_active, 1'b1);
        chk16("lap_disp_frozen", disp_bcd, 16'h0037);
        cyc(8);
        chk16("lap_time_moves", time_bcd, 16'h0039);
        chk16("lap_disp_held", disp_bcd, 16'h0037);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk1("lap_active_off", lap_active, 1'b0);
        chk16("lap_release_disp", disp_bcd, 16'h0039);

        // Stop with the prescaler at 2 of 4. After the restart the tick is 2 cycles away.
        cyc(2);
        chk16("time_0040", time_bcd, 16'h0040);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk1("stop_run", run, 1'b0);
        cyc(5);
        chk16("stop_hold_time", time_bcd, 16'h0040);
        chk1("stop_no_tick", tick, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk1("resume_run", run, 1'b1);
        cyc(1);
        chk1("resume_tick_early", tick, 1'b0);
        cyc(1);
        chk1("resume_tick_2cyc", tick, 1'b1);
        cyc(1);
        chk16("resume_time", time_bcd, 16'h0041);

        // stop_pb and lap_pb in the same cycle: stop wins. A clear while running is ignored.
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        chk1("stoplap_run", run, 1'b0);
        chk1("stoplap_lap", lap_active, 1'b0);
        chk16("stoplap_disp", disp_bcd, 16'h0041);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk1("clear_running_run", run, 1'b1);
        chk16("clear_running_time", time_bcd, 16'h0041);
        cyc(1);
        chk1("clear_running_presc", tick, 1'b1);
        cyc(1);
        chk16("clear_running_next", time_bcd, 16'h0042);

        // Count up to 59.99 and wrap to 00.00. ovf stays set until a clear.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk16("rst2_time", time_bcd, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(24000);
        chk16("time_5999", time_bcd, 16'h5999);
        chk1("pre_wrap_ovf", ovf, 1'b0);
        chk1("wrap_tick", tick, 1'b1);
        cyc(1);
        chk16("wrap_time", time_bcd, 16'h0000);
        chk1("wrap_ovf", ovf, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk1("ovf_sticky", ovf, 1'b1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk1("clear_ovf", ovf, 1'b0);
        chk16("clear_time", time_bcd, 16'h0000);

        // Take a lap at 12.34, then reset in LAP_RUN. A start is needed before counting resumes.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4937);
        chk16("time_1234", time_bcd, 16'h1234);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk1("lap1234_active", lap_active, 1'b1);
        chk16("lap1234_disp", disp_bcd, 16'h1234);
        reset = 1'b1;
        cyc(1);
        chk1("rst3_run", run, 1'b0);
        chk1("rst3_tick", tick, 1'b0);
        chk1("rst3_lap", lap_active, 1'b0);
        chk1("rst3_ovf", ovf, 1'b0);
        chk16("rst3_time", time_bcd, 16'h0000);
        chk16("rst3_disp", disp_bcd, 16'h0000);
        reset = 1'b0;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk1("lap_in_stopped", lap_active, 1'b0);
        cyc(5);
        chk1("idle_run", run, 1'b0);
        chk16("idle_time", time_bcd, 16'h0000);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(3);
        chk1("restart_no_tick", tick, 1'b0);
        cyc(1);
        chk1("restart_tick", tick, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
